// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: opening flag, zero-stuffed data, optional FCS-16, closing flag.
// Define HDLC_TX_FCS_EN to append the CRC-16-CCITT frame check sequence.
module hdlc_tx_framer #(
  parameter int MAX_BYTES = 126
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_FrameSize,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);
  localparam logic [7:0] FLAG = 8'h7E;

  typedef enum logic [2:0] {
    IDLE, START_FLAG, DATA,
`ifdef HDLC_TX_FCS_EN
    FCS,
`endif
    END_FLAG, ABORT
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0] ones_reg, ones_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg;
  logic [7:0] fetch_left_reg, fetch_left_next;
  logic       have_next_reg, have_next_next;
  logic       tail_reg, tail_next;
  logic       done_reg, done_next;
  logic       aborted_reg, aborted_next;
  logic       rd_d_reg;
`ifdef HDLC_TX_FCS_EN
  logic [15:0] crc_reg, crc_next;
  logic        fcs_hi_reg, fcs_hi_next;
`endif

  logic       stuff, tx_bit, rd, to_end, abortable;
  logic [7:0] next_byte, size_clamped;

  assign size_clamped = (Tx_FrameSize > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : Tx_FrameSize;
  // The fetched byte arrives one cycle after the strobe; if a stuffed zero delays
  // the wrap, the byte is taken from the holding register instead.
  assign next_byte = rd_d_reg ? Tx_Data : hold_reg;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    ones_next       = ones_reg;
    shift_next      = shift_reg;
    tail_next       = tail_reg;
    done_next       = 1'b0;
    aborted_next    = aborted_reg;
    to_end          = 1'b0;
    tx_bit          = 1'b1;
    abortable       = 1'b0;
`ifdef HDLC_TX_FCS_EN
    crc_next        = crc_reg;
    fcs_hi_next     = fcs_hi_reg;
    stuff           = ((state_reg == DATA) || (state_reg == FCS)) && (ones_reg == 3'd5);
`else
    stuff           = (state_reg == DATA) && (ones_reg == 3'd5);
`endif

    case (state_reg)
      START_FLAG, END_FLAG: tx_bit = FLAG[bit_cnt_reg];
      DATA:                 tx_bit = shift_reg[bit_cnt_reg];
`ifdef HDLC_TX_FCS_EN
      FCS:                  tx_bit = crc_reg[{fcs_hi_reg, bit_cnt_reg}];
`endif
      ABORT:                tx_bit = (bit_cnt_reg != 3'd0);
      default:              tx_bit = 1'b1;
    endcase

    rd = ((state_reg == START_FLAG) || (state_reg == DATA)) && (bit_cnt_reg == 3'd6) &&
         !stuff && (fetch_left_reg != 8'd0);
    fetch_left_next = fetch_left_reg - {7'd0, rd};
    have_next_next  = have_next_reg | rd;

`ifdef HDLC_TX_FCS_EN
    abortable = (state_reg == START_FLAG) || (state_reg == DATA) || (state_reg == FCS);
`else
    abortable = (state_reg == START_FLAG) || (state_reg == DATA);
`endif

    if (abortable && Tx_AbortFrame) begin
      state_next      = ABORT;
      bit_cnt_next    = 3'd0;
      ones_next       = 3'd0;
      tail_next       = 1'b0;
      have_next_next  = 1'b0;
      fetch_left_next = 8'd0;
      aborted_next    = 1'b1;
    end else if (stuff) begin
      // Inserted zero: bit counter and CRC hold, ones run restarts.
      ones_next = 3'd0;
      if (tail_reg) begin
        state_next   = END_FLAG;
        bit_cnt_next = 3'd0;
        tail_next    = 1'b0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (Tx_Enable) begin
            state_next      = START_FLAG;
            bit_cnt_next    = 3'd0;
            ones_next       = 3'd0;
            tail_next       = 1'b0;
            have_next_next  = 1'b0;
            fetch_left_next = size_clamped;
            aborted_next    = 1'b0;
`ifdef HDLC_TX_FCS_EN
            crc_next        = 16'h0000;
            fcs_hi_next     = 1'b0;
`endif
          end
        end
        START_FLAG: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          ones_next    = 3'd0;
          if (bit_cnt_reg == 3'd7) begin
            have_next_next = 1'b0;
            if (have_next_reg) begin
              state_next = DATA;
              shift_next = next_byte;
            end else begin
`ifdef HDLC_TX_FCS_EN
              state_next = FCS;
`else
              state_next = END_FLAG;
`endif
            end
          end
        end
        DATA: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          ones_next    = tx_bit ? ones_reg + 3'd1 : 3'd0;
`ifdef HDLC_TX_FCS_EN
          crc_next = {1'b0, crc_reg[15:1]} ^ ((crc_reg[0] ^ tx_bit) ? 16'h8408 : 16'h0000);
`endif
          if (bit_cnt_reg == 3'd7) begin
            have_next_next = 1'b0;
            if (have_next_reg) begin
              shift_next = next_byte;
            end else begin
`ifdef HDLC_TX_FCS_EN
              state_next  = FCS;
              fcs_hi_next = 1'b0;
`else
              to_end = 1'b1;
`endif
            end
          end
        end
`ifdef HDLC_TX_FCS_EN
        FCS: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          ones_next    = tx_bit ? ones_reg + 3'd1 : 3'd0;
          if (bit_cnt_reg == 3'd7) begin
            fcs_hi_next = 1'b1;
            to_end      = fcs_hi_reg;
          end
        end
`endif
        END_FLAG: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        ABORT: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      // A field ending on a fifth one gets its stuffed zero before the closing flag.
      if (to_end) begin
        if (tx_bit && (ones_reg == 3'd4)) tail_next = 1'b1;
        else                              state_next = END_FLAG;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      ones_reg       <= 3'd0;
      shift_reg      <= 8'd0;
      hold_reg       <= 8'd0;
      fetch_left_reg <= 8'd0;
      have_next_reg  <= 1'b0;
      tail_reg       <= 1'b0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
      rd_d_reg       <= 1'b0;
`ifdef HDLC_TX_FCS_EN
      crc_reg        <= 16'h0000;
      fcs_hi_reg     <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      ones_reg       <= ones_next;
      shift_reg      <= shift_next;
      fetch_left_reg <= fetch_left_next;
      have_next_reg  <= have_next_next;
      tail_reg       <= tail_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
      rd_d_reg       <= rd;
      if (rd_d_reg) hold_reg <= Tx_Data;
`ifdef HDLC_TX_FCS_EN
      crc_reg        <= crc_next;
      fcs_hi_reg     <= fcs_hi_next;
`endif
    end
  end

  assign Tx              = stuff ? 1'b0 : tx_bit;
  assign Tx_RdBuff       = rd;
  assign Tx_ValidFrame   = (state_reg != IDLE);
  assign Tx_Done         = done_reg;
  assign Tx_AbortedTrans = aborted_reg;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed self-checking bench for hdlc_tx_framer; follows HDLC_TX_FCS_EN when it is defined.
module tb_hdlc_tx_framer;
`ifdef HDLC_TX_FCS_EN
  localparam int FCS_BITS = 16;
`else
  localparam int FCS_BITS = 0;
`endif

  logic       Clk = 1'b0;
  logic       Rst, Tx_Enable, Tx_AbortFrame;
  logic [7:0] Tx_FrameSize, Tx_Data;
  logic       Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:255];
  bit   line[$];
  bit   exp_q[$];
  int   rd_cnt, rd_idx, done_cnt, cyc_cnt;
  bit   rd_prev, prev_valid;
  logic [2:0] done_shape;
  logic [1:0] first_vt;

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_FrameSize(Tx_FrameSize), .Tx_Data(Tx_Data), .Tx_RdBuff(Tx_RdBuff), .Tx(Tx),
    .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
  );

  // Advance to the next falling edge, play the Tx buffer and record the line.
  task automatic tick();
    @(negedge Clk);
    if (rd_prev) begin
      Tx_Data = mem[rd_idx];
      rd_idx++;
    end else begin
      Tx_Data = 8'hA5 ^ 8'(cyc_cnt);
    end
    rd_prev = Tx_RdBuff;
    cyc_cnt++;
    if (Tx_ValidFrame) line.push_back(Tx);
    if (Tx_RdBuff) rd_cnt++;
    if (Tx_Done) begin
      done_cnt++;
      done_shape = {prev_valid, Tx_ValidFrame, Tx};
    end
    prev_valid = Tx_ValidFrame;
  endtask

  task automatic clear_mon();
    line.delete();
    rd_cnt = 0; rd_idx = 0; done_cnt = 0; rd_prev = 1'b0; done_shape = 3'b000;
  endtask

  task automatic start_frame(input int size_in);
    clear_mon();
    Tx_FrameSize = size_in[7:0];
    Tx_Enable = 1'b1;
    tick();
    Tx_Enable = 1'b0;
    first_vt = {Tx_ValidFrame, Tx};
  endtask

  task automatic run_frame(input int size_in);
    int guard;
    start_frame(size_in);
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      tick();
      guard++;
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
    return {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'h8408 : 16'h0000);
  endfunction

  task automatic push_stuffed(input bit b, inout int ones);
    exp_q.push_back(b);
    ones = b ? ones + 1 : 0;
    if (ones == 5) begin
      exp_q.push_back(1'b0);
      ones = 0;
    end
  endtask

  // Reference line sequence for the first n bytes of mem.
  task automatic build_exp(input int n);
    logic [15:0] c;
    logic [7:0]  flag_v;
    int ones;
    exp_q.delete();
    c = 16'h0000; ones = 0; flag_v = 8'h7E;
    for (int i = 0; i < 8; i++) exp_q.push_back(flag_v[i]);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) begin
        c = crc_step(c, mem[k][i]);
        push_stuffed(mem[k][i], ones);
      end
    if (FCS_BITS == 16)
      for (int i = 0; i < 16; i++) push_stuffed(c[i], ones);
    for (int i = 0; i < 8; i++) exp_q.push_back(flag_v[i]);
  endtask

  function automatic int line_diff();
    int d;
    d = (line.size() != exp_q.size()) ? 1000 : 0;
    for (int i = 0; i < line.size() && i < exp_q.size(); i++)
      if (line[i] != exp_q[i]) d++;
    return d;
  endfunction

  task automatic test_reset();
    Rst = 1'b1; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_FrameSize = 8'd0; Tx_Data = 8'd0;
    clear_mon(); cyc_cnt = 0; prev_valid = 1'b0;
    tick(); tick();
    tests++;
    if ({Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 10000",
               {Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans});
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if ({Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans} !== 5'b10000) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_200: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_zero_byte();
    mem[0] = 8'h00;
    run_frame(1);
    build_exp(1);
    tests++;
    if (first_vt !== 2'b10) begin fails++; $display("FAIL zero_start_latency: got %b expected 10", first_vt); end
    tests++;
    if (line.size() !== 24 + FCS_BITS) begin
      fails++; $display("FAIL zero_length: got %0d expected %0d", line.size(), 24 + FCS_BITS);
    end
    tests++;
    if (line_diff() !== 0) begin fails++; $display("FAIL zero_line: got %0d bit errors expected 0", line_diff()); end
    tests++;
    if (rd_cnt !== 1) begin fails++; $display("FAIL zero_rdbuff: got %0d expected 1", rd_cnt); end
    tests++;
    if (done_cnt !== 1 || done_shape !== 3'b101) begin
      fails++; $display("FAIL zero_done: got count %0d shape %b expected 1 101", done_cnt, done_shape);
    end
  endtask

  task automatic test_ones_byte();
    logic [8:0] f9;
    mem[0] = 8'hFF;
    run_frame(1);
    build_exp(1);
    f9 = 'x;
    if (line.size() >= 17) for (int i = 0; i < 9; i++) f9[i] = line[8 + i];
    tests++;
    if (f9 !== 9'h1DF) begin fails++; $display("FAIL ones_data_field: got %h expected 1df", f9); end
    tests++;
    if (line.size() !== 25 + FCS_BITS) begin
      fails++; $display("FAIL ones_length: got %0d expected %0d", line.size(), 25 + FCS_BITS);
    end
    tests++;
    if (line_diff() !== 0) begin fails++; $display("FAIL ones_line: got %0d bit errors expected 0", line_diff()); end
  endtask

  task automatic test_empty_frame();
    run_frame(0);
    build_exp(0);
    tests++;
    if (line.size() !== 16 + FCS_BITS || line_diff() !== 0) begin
      fails++; $display("FAIL empty_line: got len %0d errs %0d expected len %0d errs 0",
                        line.size(), line_diff(), 16 + FCS_BITS);
    end
    tests++;
    if (rd_cnt !== 0 || done_cnt !== 1) begin
      fails++; $display("FAIL empty_counts: got rd %0d done %0d expected 0 1", rd_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    logic [7:0] ab;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    start_frame(4);
    repeat (18) tick();
    Tx_AbortFrame = 1'b1;
    tick();
    Tx_AbortFrame = 1'b0;
    ab[0] = Tx;
    for (int i = 1; i < 8; i++) begin
      tick();
      ab[i] = Tx;
    end
    tests++;
    if (ab !== 8'hFE) begin fails++; $display("FAIL abort_pattern: got %h expected fe", ab); end
    tests++;
    if (line.size() !== 27) begin fails++; $display("FAIL abort_valid_len: got %0d expected 27", line.size()); end
    tick();
    tests++;
    if ({Tx_ValidFrame, Tx, Tx_AbortedTrans} !== 3'b011) begin
      fails++; $display("FAIL abort_after: got %b expected 011", {Tx_ValidFrame, Tx, Tx_AbortedTrans});
    end
    repeat (30) tick();
    tests++;
    if (done_cnt !== 0 || rd_cnt !== 2) begin
      fails++; $display("FAIL abort_counts: got done %0d rd %0d expected 0 2", done_cnt, rd_cnt);
    end
    run_frame(1);
    tests++;
    if (Tx_AbortedTrans !== 1'b0 || done_cnt !== 1) begin
      fails++; $display("FAIL abort_clear: got aborted %b done %0d expected 0 1", Tx_AbortedTrans, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 10; k++) mem[k] = 8'(k * 37 + 5);
    mem[1] = 8'hFF;
    start_frame(10);
    repeat (30) tick();
    Rst = 1'b1;
    tick();
    tests++;
    if ({Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans} !== 5'b10000) begin
      fails++; $display("FAIL midreset_outputs: got %b expected 10000",
                        {Tx, Tx_RdBuff, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans});
    end
    tick();
    Rst = 1'b0;
    tick();
    run_frame(2);
    build_exp(2);
    tests++;
    if (line_diff() !== 0 || rd_cnt !== 2 || done_cnt !== 1) begin
      fails++; $display("FAIL midreset_next_frame: got errs %0d rd %0d done %0d expected 0 2 1",
                        line_diff(), rd_cnt, done_cnt);
    end
  endtask

  task automatic test_max_frame();
    bit rx[$];
    int ones, bad_stuff, bad_bytes;
    logic [15:0] c, rx_fcs;
    logic [7:0] b;
    for (int k = 0; k < 256; k++) mem[k] = 8'h7E;
    run_frame(200);
    build_exp(126);
    tests++;
    if (rd_cnt !== 126) begin fails++; $display("FAIL max_rdbuff: got %0d expected 126", rd_cnt); end
    tests++;
    if (line_diff() !== 0) begin fails++; $display("FAIL max_line: got %0d bit errors expected 0", line_diff()); end
    // Independent receiver: strip flags, remove stuffed zeros, rebuild bytes.
    ones = 0; bad_stuff = 0; bad_bytes = 0; c = 16'h0000; rx_fcs = 16'h0000;
    for (int i = 8; i < line.size() - 8; i++) begin
      if (ones == 5) begin
        if (line[i] != 1'b0) bad_stuff++;
        ones = 0;
      end else begin
        rx.push_back(line[i]);
        ones = line[i] ? ones + 1 : 0;
      end
    end
    tests++;
    if (bad_stuff !== 0 || rx.size() !== 126 * 8 + FCS_BITS) begin
      fails++; $display("FAIL max_destuff: got bad %0d bits %0d expected 0 %0d",
                        bad_stuff, rx.size(), 126 * 8 + FCS_BITS);
    end else begin
      for (int k = 0; k < 126; k++) begin
        for (int i = 0; i < 8; i++) begin
          b[i] = rx[k * 8 + i];
          c = crc_step(c, rx[k * 8 + i]);
        end
        if (b !== 8'h7E) bad_bytes++;
      end
      for (int i = 0; i < FCS_BITS; i++) rx_fcs[i] = rx[126 * 8 + i];
      if (FCS_BITS == 0) c = 16'h0000;
      tests++;
      if (bad_bytes !== 0 || rx_fcs !== c) begin
        fails++; $display("FAIL max_receiver: got bad bytes %0d fcs %h expected 0 %h", bad_bytes, rx_fcs, c);
      end
    end
  endtask

  task automatic test_back_to_back();
    mem[0] = 8'h0F; mem[1] = 8'hF0;
    run_frame(2);
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL b2b_first_done: got %0d expected 1", done_cnt); end
    run_frame(2);
    build_exp(2);
    tests++;
    if (first_vt !== 2'b10) begin fails++; $display("FAIL b2b_start: got %b expected 10", first_vt); end
    tests++;
    if (line_diff() !== 0 || done_cnt !== 1) begin
      fails++; $display("FAIL b2b_second_frame: got errs %0d done %0d expected 0 1", line_diff(), done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_zero_byte();
    test_ones_byte();
    test_empty_frame();
    test_abort();
    test_reset_mid_frame();
    test_max_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
